disp_scan_mux4: RTL and testbench

//  Gathers four BCD digit channels onto one shared 7-segment bus.

---
 rtl/disp_scan_mux4.sv | 139 +++++++++++++
 tb/tb_disp_scan_mux4.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux4.sv
// -----------------------------------------------------------------------------
// disp_scan_mux4
//   Time-division scanner that gathers four BCD digit channels onto a single
//   shared common-anode 7-segment bus. A prescaler divides clk down to one
//   digit slot every SCAN_DIV cycles; the slot index rotates 0,1,2,3,0,...
//   The anode select and the segment pattern are registered together so both
//   change on the same edge, one cycle after sel or a digit input changes.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 2)
//   BLANK_LZ  1 = blank leading zeros on dig3..dig1 (dig0 always shown)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   scan enable; 0 = display dark, scan frozen
//   dig0  in   BCD units digit
//   dig1  in   BCD tens digit
//   dig2  in   BCD hundreds digit
//   dig3  in   BCD thousands digit
//   an    out  anode enables, active-low, one-hot-zero (an[i] -> digit i)
//   seg   out  segments {g,f,e,d,c,b,a}, active-low
//   sel   out  index of the currently selected digit slot
//   tick  out  1-cycle pulse on the last cycle of each slot
// -----------------------------------------------------------------------------
module disp_scan_mux4 #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic [1:0] sel,
  output logic       tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          cnt_last;

  logic [3:0]    cur_dig;
  logic          cur_blank;
  logic [6:0]    cur_seg;

  // Leading-zero chain: a digit is a leading zero when it and every higher
  // digit are zero. Any non-zero value (including >9) breaks the chain.
  logic          lz3;
  logic          lz2;
  logic          lz1;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // out-of-range value shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_last = (cnt == CNT_LAST);
    cnt_nxt  = cnt_last ? '0 : cnt + 1'b1;
  end

  always_comb begin
    lz3 = (dig3 == 4'd0);
    lz2 = lz3 && (dig2 == 4'd0);
    lz1 = lz2 && (dig1 == 4'd0);
  end

  always_comb begin
    cur_dig   = dig0;
    cur_blank = 1'b0;
    case (sel)
      2'd0: begin
        cur_dig   = dig0;
        cur_blank = 1'b0;
      end
      2'd1: begin
        cur_dig   = dig1;
        cur_blank = BLANK_LZ && lz1;
      end
      2'd2: begin
        cur_dig   = dig2;
        cur_blank = BLANK_LZ && lz2;
      end
      default: begin
        cur_dig   = dig3;
        cur_blank = BLANK_LZ && lz3;
      end
    endcase
    cur_seg = cur_blank ? '1 : bcd_to_seg(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sel  <= '0;
      tick <= 1'b0;
      an   <= '1;
      seg  <= '1;
    end else begin
      if (en) begin
        cnt <= cnt_nxt;
        if (cnt_last) begin
          sel <= sel + 2'd1;
        end
        // Registered tick lines up with the cycle in which cnt sits at its
        // last value, so it is computed from the count being loaded.
        tick <= (cnt_nxt == CNT_LAST);
        an   <= ~(4'b0001 << sel);
        seg  <= cur_seg;
      end else begin
        tick <= 1'b0;
        an   <= '1;
        seg  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_mux4.sv
module tb_disp_scan_mux4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] dig0, dig1, dig2, dig3;

  logic [3:0] an,   an_nb;
  logic [6:0] seg,  seg_nb;
  logic [1:0] sel,  sel_nb;
  logic       tick, tick_nb;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  disp_scan_mux4 #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .an(an), .seg(seg), .sel(sel), .tick(tick)
  );

  disp_scan_mux4 #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .en(en),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .an(an_nb), .seg(seg_nb), .sel(sel_nb), .tick(tick_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digs(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
    dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0;
  endtask

  // Leaves the bench on the first cycle of slot s (sel==s, an still shows
  // the previous slot). Bounded wait.
  task automatic goto_slot_start(input logic [1:0] s);
    logic [1:0] prev;
    bit found;
    prev  = s - 2'd1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick === 1'b1 && sel === prev) begin
        step();
        found = 1;
        break;
      end
    end
    if (!found) check("goto_slot_timeout", 32'd0, 32'd1);
  endtask

  logic [6:0] seg_t1 [4];
  logic [6:0] exp_blz [4];
  logic [6:0] exp_nb  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_t1  = '{7'h19, 7'h30, 7'h24, 7'h79};   // slots 0..3 for digits 1,2,3,4
    exp_blz = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    exp_nb  = '{7'h40, 7'h12, 7'h40, 7'h40};

    rst = 1'b1;
    en  = 1'b0;
    set_digs(4'd1, 4'd2, 4'd3, 4'd4);
    #1;
    step();
    step();
    check("rst_sel",  32'(sel),  32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);

    // Test 1: basic scan, digits 1,2,3,4
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      int ps;
      step();
      ps = ((k - 1) / 4) % 4;
      check("t1_sel",  32'(sel),  32'((k / 4) % 4));
      check("t1_tick", 32'(tick), 32'((k % 4) == 3));
      check("t1_an",   32'(an),   32'(~(4'b0001 << ps) & 4'hF));
      check("t1_seg",  32'(seg),  32'(seg_t1[ps]));
    end

    // Test 2: digits 0,0,5,0 with and without blanking
    set_digs(4'd0, 4'd0, 4'd5, 4'd0);
    for (int s = 0; s < 4; s++) begin
      goto_slot_start(2'(s));
      step();
      check("t2_an",     32'(an),     32'(~(4'b0001 << s) & 4'hF));
      check("t2_seg",    32'(seg),    32'(exp_blz[s]));
      check("t2_seg_nb", 32'(seg_nb), 32'(exp_nb[s]));
    end

    // Test 3: all zero, then dig1 out of range
    set_digs(4'd0, 4'd0, 4'd0, 4'd0);
    goto_slot_start(2'd0); step();
    check("t3_z_s0_seg", 32'(seg), 32'h40);
    goto_slot_start(2'd1); step();
    check("t3_z_s1_an",  32'(an),  32'hD);
    check("t3_z_s1_seg", 32'(seg), 32'h7F);
    set_digs(4'd0, 4'd0, 4'd12, 4'd0);
    goto_slot_start(2'd2); step();
    check("t3_d_s2_seg", 32'(seg), 32'h7F);
    goto_slot_start(2'd0); step();
    check("t3_d_s0_seg", 32'(seg), 32'h40);
    goto_slot_start(2'd1); step();
    check("t3_d_s1_seg", 32'(seg), 32'h3F);

    // Test 4: en low for 6 cycles during slot 2
    set_digs(4'd1, 4'd2, 4'd3, 4'd4);
    goto_slot_start(2'd2);
    step();
    check("t4_pre_an",  32'(an),  32'hB);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t4_off_an",   32'(an),   32'hF);
      check("t4_off_seg",  32'(seg),  32'h7F);
      check("t4_off_tick", 32'(tick), 32'd0);
      check("t4_off_sel",  32'(sel),  32'd2);
    end
    en = 1'b1;
    step();
    check("t4_r1_an",   32'(an),   32'hB);
    check("t4_r1_seg",  32'(seg),  32'h24);
    check("t4_r1_tick", 32'(tick), 32'd0);
    check("t4_r1_sel",  32'(sel),  32'd2);
    step();
    check("t4_r2_tick", 32'(tick), 32'd1);
    check("t4_r2_sel",  32'(sel),  32'd2);
    step();
    check("t4_r3_tick", 32'(tick), 32'd0);
    check("t4_r3_sel",  32'(sel),  32'd3);

    // Test 5: reset at cnt=2, sel=3
    goto_slot_start(2'd3);
    step();
    step();
    rst = 1'b1;
    step();
    check("t5_sel",  32'(sel),  32'd0);
    check("t5_tick", 32'(tick), 32'd0);
    check("t5_an",   32'(an),   32'hF);
    check("t5_seg",  32'(seg),  32'h7F);
    rst = 1'b0;
    step();
    check("t5_c1_tick", 32'(tick), 32'd0);
    step();
    check("t5_c2_tick", 32'(tick), 32'd0);
    step();
    check("t5_c3_tick", 32'(tick), 32'd1);
    check("t5_c3_sel",  32'(sel),  32'd0);
    step();
    check("t5_c4_sel",  32'(sel),  32'd1);

    // Test 6: dig0 7 -> 8 mid-slot 0
    set_digs(4'd1, 4'd2, 4'd3, 4'd7);
    goto_slot_start(2'd0);
    step();
    check("t6_pre_seg", 32'(seg), 32'h78);
    check("t6_pre_an",  32'(an),  32'hE);
    dig0 = 4'd8;
    step();
    check("t6_post_seg", 32'(seg), 32'h00);
    check("t6_post_an",  32'(an),  32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
